// File: rtl/vga_sprite_pkg.sv
// vga_sprite_pkg: shared coordinate type, default geometry and saturating step helpers
package vga_sprite_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_COORD_W = 12;
  typedef logic [DEF_COORD_W-1:0] coord_t;
  function automatic coord_t sat_add(coord_t a, coord_t s, coord_t m);
    return (a > m - s) ? m : a + s;
  endfunction
  function automatic coord_t sat_sub(coord_t a, coord_t s);
    return (a < s) ? '0 : a - s;
  endfunction
endpackage

// File: rtl/vga_sprite_overlay_sprite_pos_reg.sv
// sprite_pos_reg: one movable sprite rectangle with saturating moves and a pixel hit test
module sprite_pos_reg
  import vga_sprite_pkg::*;
#(
  parameter int X0 = 100,
  parameter int Y0 = 100,
  parameter int W = 50,
  parameter int H = 50,
  parameter int STEP = 10,
  parameter int X_MAX = 590,
  parameter int Y_MAX = 430
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_en,
  input  logic   i_l,
  input  logic   i_r,
  input  logic   i_u,
  input  logic   i_d,
  input  coord_t i_px,
  input  coord_t i_py,
  output coord_t o_x,
  output coord_t o_y,
  output logic   o_hit
);
  coord_t r_x, r_y;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_x <= coord_t'(X0);
      r_y <= coord_t'(Y0);
    end else if (i_en) begin
      r_x <= (i_l && !i_r) ? sat_sub(r_x, coord_t'(STEP)) :
             (i_r && !i_l) ? sat_add(r_x, coord_t'(STEP), coord_t'(X_MAX)) : r_x;
      r_y <= (i_u && !i_d) ? sat_sub(r_y, coord_t'(STEP)) :
             (i_d && !i_u) ? sat_add(r_y, coord_t'(STEP), coord_t'(Y_MAX)) : r_y;
    end
  assign o_x = r_x;
  assign o_y = r_y;
  assign o_hit = (i_px >= r_x) && (i_px < r_x + coord_t'(W)) &&
                 (i_py >= r_y) && (i_py < r_y + coord_t'(H));
endmodule

// File: rtl/vga_sprite_overlay.sv
// vga_sprite_overlay: multi-sprite palette-index overlay with frame-synchronous button moves
module vga_sprite_overlay
  import vga_sprite_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 50,
  parameter int STEP = 10,
  parameter int TICK_DIV = 1000000,
  parameter int COORD_W = DEF_COORD_W,
  parameter int IDX_W = 8,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                         iVGA_CLK,
  input  logic                         iRST,
  input  logic                         iBLANK_n,
  input  logic                         iHS,
  input  logic                         iVS,
  input  logic [IDX_W-1:0]             iBG_INDEX,
  input  logic [NUM_SPRITES*IDX_W-1:0] iSPRITE_COLOR,
  input  logic [SEL_W-1:0]             iSEL,
  input  logic                         iMOVE_L,
  input  logic                         iMOVE_R,
  input  logic                         iMOVE_U,
  input  logic                         iMOVE_D,
  output logic [IDX_W-1:0]             oINDEX,
  output logic                         oHIT,
  output logic [COORD_W-1:0]           oSEL_X,
  output logic [COORD_W-1:0]           oSEL_Y
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  coord_t r_px, r_py, r_sel_x, r_sel_y, w_sel_x, w_sel_y;
  coord_t w_x [NUM_SPRITES];
  coord_t w_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit;
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_index, w_index;
  logic r_sync_low, r_pend, r_hit;
  logic w_sync_low, w_fs, w_tick, w_apply;
  assign w_sync_low = !iHS && !iVS;
  // frame_start is the first cycle of the joint hsync/vsync low window
  assign w_fs = w_sync_low && !r_sync_low;
  assign w_tick = r_div == DIV_W'(TICK_DIV - 1);
  assign w_apply = w_fs && (r_pend || w_tick);
  always_ff @(posedge iVGA_CLK)
    if (iRST) begin
      r_px <= '0;
      r_py <= '0;
      r_sync_low <= 1'b0;
      r_pend <= 1'b0;
      r_div <= '0;
    end else begin
      r_sync_low <= w_sync_low;
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      r_pend <= !w_fs && (r_pend || w_tick);
      if (w_sync_low) begin
        r_px <= '0;
        r_py <= '0;
      end else if (iBLANK_n) begin
        r_px <= (r_px == coord_t'(H_ACTIVE - 1)) ? '0 : r_px + coord_t'(1);
        if (r_px == coord_t'(H_ACTIVE - 1))
          r_py <= (r_py == coord_t'(V_ACTIVE - 1)) ? '0 : r_py + coord_t'(1);
      end
    end
  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_spr
    sprite_pos_reg #(
      .X0(100 + 64 * k), .Y0(100), .W(SPRITE_W), .H(SPRITE_H), .STEP(STEP),
      .X_MAX(H_ACTIVE - SPRITE_W), .Y_MAX(V_ACTIVE - SPRITE_H)
    ) u_spr (
      .i_clk(iVGA_CLK), .i_rst(iRST), .i_en(w_apply && (iSEL == SEL_W'(k))),
      .i_l(!iMOVE_L), .i_r(!iMOVE_R), .i_u(!iMOVE_U), .i_d(!iMOVE_D),
      .i_px(r_px), .i_py(r_py), .o_x(w_x[k]), .o_y(w_y[k]), .o_hit(w_hit[k])
    );
  end
  always_comb begin
    w_index = iBG_INDEX;
    w_sel_x = '0;
    w_sel_y = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      if (w_hit[k]) w_index = iSPRITE_COLOR[k*IDX_W +: IDX_W];
    for (int k = 0; k < NUM_SPRITES; k++)
      if (iSEL == SEL_W'(k)) begin
        w_sel_x = w_x[k];
        w_sel_y = w_y[k];
      end
  end
  always_ff @(posedge iVGA_CLK)
    if (iRST) begin
      r_index <= '0;
      r_hit <= 1'b0;
      r_sel_x <= '0;
      r_sel_y <= '0;
    end else begin
      r_index <= w_index;
      r_hit <= |w_hit;
      r_sel_x <= w_sel_x;
      r_sel_y <= w_sel_y;
    end
  assign oINDEX = r_index;
  assign oHIT = r_hit;
  assign oSEL_X = COORD_W'(r_sel_x);
  assign oSEL_Y = COORD_W'(r_sel_y);
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// tb_vga_sprite_overlay: directed and randomized checks against a behavioural overlay model
module tb_vga_sprite_overlay;
  localparam int N = 4, TD = 4, HA = 640, VA = 480, SW = 50, SH = 50, ST = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, blank_n, hs, vs, ml, mr, mu, md;
  logic [7:0] bg;
  logic [31:0] col;
  logic [1:0] sel;
  logic [7:0] o_index;
  logic o_hit;
  logic [11:0] o_sx, o_sy;
  vga_sprite_overlay #(.TICK_DIV(TD)) dut (
    .iVGA_CLK(clk), .iRST(rst), .iBLANK_n(blank_n), .iHS(hs), .iVS(vs),
    .iBG_INDEX(bg), .iSPRITE_COLOR(col), .iSEL(sel),
    .iMOVE_L(ml), .iMOVE_R(mr), .iMOVE_U(mu), .iMOVE_D(md),
    .oINDEX(o_index), .oHIT(o_hit), .oSEL_X(o_sx), .oSEL_Y(o_sy)
  );
  int mx[N], my[N];
  int mpx, mpy, mdiv, e_sx, e_sy, ncmp, nfail;
  bit mpend, mprev, valid;
  logic [7:0] e_index;
  logic e_hit;
  function automatic int clamp(int v, int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction
  task automatic chk(string tag, int got, int exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    int hk;
    bit slow, fs, tick;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mx[k] = 100 + 64 * k;
        my[k] = 100;
      end
      {mpx, mpy, mdiv, e_sx, e_sy} = '0;
      {mpend, mprev, e_hit} = '0;
      e_index = '0;
      valid = 1'b1;
    end else begin
      hk = -1;
      for (int k = N - 1; k >= 0; k--)
        if (mpx >= mx[k] && mpx < mx[k] + SW && mpy >= my[k] && mpy < my[k] + SH) hk = k;
      e_index = (hk >= 0) ? col[hk*8 +: 8] : bg;
      e_hit = hk >= 0;
      e_sx = mx[sel];
      e_sy = my[sel];
      slow = !hs && !vs;
      fs = slow && !mprev;
      tick = mdiv == TD - 1;
      if (fs && (mpend || tick)) begin
        mx[sel] = clamp(mx[sel] + ST * (int'(!mr) - int'(!ml)), HA - SW);
        my[sel] = clamp(my[sel] + ST * (int'(!md) - int'(!mu)), VA - SH);
      end
      mpend = !fs && (mpend || tick);
      mprev = slow;
      mdiv = (mdiv + 1) % TD;
      if (slow) begin
        mpx = 0;
        mpy = 0;
      end else if (blank_n) begin
        mpx++;
        if (mpx == HA) begin
          mpx = 0;
          mpy = (mpy + 1) % VA;
        end
      end
    end
    @(posedge clk);
    #1;
    if (valid) begin
      chk("model_index", int'(o_index), int'(e_index));
      chk("model_hit", int'(o_hit), int'(e_hit));
      chk("model_sel_x", int'(o_sx), e_sx);
      chk("model_sel_y", int'(o_sy), e_sy);
    end
  endtask
  task automatic frame(int idle);
    repeat (idle) cyc();
    hs = 1'b0;
    vs = 1'b0;
    cyc();
    hs = 1'b1;
    vs = 1'b1;
  endtask
  initial begin
    int p, q;
    logic [7:0] bsave;
    {ncmp, nfail} = '0;
    valid = 1'b0;
    rst = 1'b1;
    blank_n = 1'b0;
    {hs, vs, ml, mr, mu, md} = 6'h3f;
    bg = 8'h00;
    col = 32'h44_33_22_11;
    sel = 2'd0;
    repeat (3) cyc();
    chk("reset_index", int'(o_index), 0);
    chk("reset_hit", int'(o_hit), 0);
    rst = 1'b0;
    cyc();
    chk("reset_s0_x", int'(o_sx), 100);
    chk("reset_s0_y", int'(o_sy), 100);
    sel = 2'd1;
    cyc();
    chk("reset_s1_x", int'(o_sx), 164);
    sel = 2'd0;
    mr = 1'b0;
    frame(5);
    cyc();
    chk("move_r", int'(o_sx), 110);
    mr = 1'b1;
    frame(5);
    cyc();
    cyc();
    chk("released", int'(o_sx), 110);
    mr = 1'b0;
    repeat (47) frame(3);
    cyc();
    chk("reach_580", int'(o_sx), 580);
    for (int i = 0; i < 3; i++) begin
      frame(3);
      cyc();
      chk("sat_right", int'(o_sx), 590);
    end
    mr = 1'b1;
    mu = 1'b0;
    repeat (11) frame(3);
    cyc();
    chk("sat_up", int'(o_sy), 0);
    mu = 1'b1;
    ml = 1'b0;
    mr = 1'b0;
    md = 1'b0;
    frame(3);
    cyc();
    chk("lr_hold_x", int'(o_sx), 590);
    chk("down_y", int'(o_sy), 10);
    {ml, mr, md} = 3'b111;
    ml = 1'b0;
    repeat (46) frame(3);
    ml = 1'b1;
    mu = 1'b0;
    frame(3);
    sel = 2'd1;
    repeat (10) frame(3);
    mu = 1'b1;
    sel = 2'd0;
    cyc();
    chk("s0_x_130", int'(o_sx), 130);
    chk("s0_y_0", int'(o_sy), 0);
    col = 32'h77_66_05_02;
    frame(1);
    blank_n = 1'b1;
    for (int i = 0; i < 3 * HA; i++) begin
      bg = 8'($urandom);
      bsave = bg;
      p = mpx;
      q = mpy;
      cyc();
      if (p == 170 && q == 1) begin
        chk("overlap_index", int'(o_index), 8'h02);
        chk("overlap_hit", int'(o_hit), 1);
      end
      if (p == 99 && q == 1) begin
        chk("bg_index", int'(o_index), int'(bsave));
        chk("bg_hit", int'(o_hit), 0);
      end
    end
    for (int i = 0; i < 2000; i++) begin
      blank_n = ($urandom_range(0, 7) != 0);
      sel = 2'($urandom);
      {ml, mr, mu, md} = 4'($urandom);
      bg = 8'($urandom);
      if ($urandom_range(0, 63) == 0) col = $urandom;
      if ($urandom_range(0, 39) == 0) {hs, vs} = 2'b00;
      else {hs, vs} = {1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 29) != 0)};
      cyc();
    end
    blank_n = 1'b0;
    {hs, vs, ml, mr, mu, md} = 6'h3f;
    sel = 2'd0;
    mr = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    cyc();
    hs = 1'b1;
    vs = 1'b1;
    cyc();
    cyc();
    chk("rst_discard_x", int'(o_sx), 100);
    chk("rst_discard_y", int'(o_sy), 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
